pmalu_pipe: RTL



---
 rtl/pmalu_pkg.sv | 27 ++
 rtl/pmalu_core.sv | 83 ++++++++
 rtl/pmalu_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pmalu_pkg.sv
// pmalu_pkg -- shared constants for the pipelined ALU (pmalu_pipe / pmalu_core).
//   Opcode map : OP_ADD..OP_XOR (3-bit, same map as the old 4-bit ALU)
//   Flag bits  : FLG_C, FLG_Z, FLG_N, FLG_V inside a FLAG_W-bit flag word
// Optional feature macro used by the design files: PMALU_SAT_EN
package pmalu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_PASSB = 3'b010;
    localparam logic [2:0] OP_PASSA = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_NOTA  = 3'b110;
    localparam logic [2:0] OP_XOR   = 3'b111;

    localparam int FLG_C  = 0;
    localparam int FLG_Z  = 1;
    localparam int FLG_N  = 2;
    localparam int FLG_V  = 3;
    localparam int FLAG_W = 4;

    // True for the two opcodes that go through the adder and produce C/V.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/pmalu_core.sv
// pmalu_core -- purely combinational WIDTH-bit ALU evaluated between the
// two pipeline stages of pmalu_pipe.
//   op    : 3-bit opcode (see pmalu_pkg)
//   a, b  : WIDTH-bit operands
//   c0    : carry-in already selected by the pipeline (cin or stored C)
//   y     : WIDTH-bit result
//   flags : {V,N,Z,C}
//   sat   : result was clamped (only possible when PMALU_SAT_EN is defined)
// Macro PMALU_SAT_EN: unsigned saturation of ADD overflow / SUB borrow.
module pmalu_core
    import pmalu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              c0,
    output logic [WIDTH-1:0]  y,
    output logic [FLAG_W-1:0] flags,
    output logic              sat
);

    logic [WIDTH-1:0] w_op2;
    logic [WIDTH:0]   w_sum;
    logic             w_arith;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_raw;

    // SUB reuses the adder with the second operand inverted; c0=1 completes
    // the two's complement so a-b falls out without a separate subtractor.
    assign w_arith = is_arith(op);
    assign w_op2   = (op == OP_SUB) ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, c0};
    assign w_carry = w_arith & w_sum[WIDTH];
    assign w_ovf   = w_arith & (a[WIDTH-1] == w_op2[WIDTH-1])
                             & (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        w_raw = '0;
        case (op)
            OP_ADD,
            OP_SUB:   w_raw = w_sum[WIDTH-1:0];
            OP_PASSB: w_raw = b;
            OP_PASSA: w_raw = a;
            OP_AND:   w_raw = a & b;
            OP_OR:    w_raw = a | b;
            OP_NOTA:  w_raw = ~a;
            OP_XOR:   w_raw = a ^ b;
            default:  w_raw = '0;
        endcase
    end

`ifdef PMALU_SAT_EN
    // Clamp unsigned overflow to all-ones and borrow to zero. C and V still
    // describe the raw adder result so software can tell what happened.
    always_comb begin
        y   = w_raw;
        sat = 1'b0;
        if (op == OP_ADD && w_carry) begin
            y   = '1;
            sat = 1'b1;
        end else if (op == OP_SUB && !w_carry) begin
            y   = '0;
            sat = 1'b1;
        end
    end
`else
    assign y   = w_raw;
    assign sat = 1'b0;
`endif

    // Z and N always follow the value actually delivered on y.
    always_comb begin
        flags        = '0;
        flags[FLG_C] = w_carry;
        flags[FLG_Z] = (y == '0);
        flags[FLG_N] = y[WIDTH-1];
        flags[FLG_V] = w_ovf;
    end

endmodule

// File: rtl/pmalu_pipe.sv
// pmalu_pipe -- two-stage pipelined WIDTH-bit ALU with status flags and
// valid/ready handshakes on both sides.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid / in_ready : operation handshake {op,a,b,cin,use_cf}
//   use_cf              : take carry-in from the stored C flag instead of cin
//   out_valid/out_ready : result handshake {y,flags,sat}
//   flags               : {V,N,Z,C} of the result on y
//   cf                  : architectural carry flag
//   sat                 : saturation on this result (0 unless PMALU_SAT_EN)
// Macro PMALU_SAT_EN enables unsigned saturation inside pmalu_core.
module pmalu_pipe
    import pmalu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              use_cf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic [FLAG_W-1:0] flags,
    output logic              cf,
    output logic              sat
);

    logic              r_s1_valid;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_cin;
    logic              r_use_cf;

    logic              r_s2_valid;
    logic [WIDTH-1:0]  r_y;
    logic [FLAG_W-1:0] r_flags;
    logic              r_sat;
    logic              r_cf;

    logic              w_s2_load;
    logic              w_accept;
    logic              w_c0;
    logic [WIDTH-1:0]  w_y;
    logic [FLAG_W-1:0] w_flags;
    logic              w_sat;

    // Stage 2 takes stage 1 whenever it is empty or being drained this cycle;
    // stage 1 can accept whenever it is empty or moving on. in_valid never
    // feeds in_ready.
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_accept  = in_valid && in_ready;

    // Chained ops read cf as it stands before the loading edge, i.e. the carry
    // of the op immediately ahead of them.
    assign w_c0 = r_use_cf ? r_cf : r_cin;

    pmalu_core #(.WIDTH(WIDTH)) u_core (
        .op    (r_op),
        .a     (r_a),
        .b     (r_b),
        .c0    (w_c0),
        .y     (w_y),
        .flags (w_flags),
        .sat   (w_sat)
    );

    // Stage 1: operand register, held while stage 2 is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_cin      <= 1'b0;
            r_use_cf   <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_op       <= op;
            r_a        <= a;
            r_b        <= b;
            r_cin      <= cin;
            r_use_cf   <= use_cf;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register plus the architectural carry flag, which only
    // changes when a new result is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_flags    <= '0;
            r_sat      <= 1'b0;
            r_cf       <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_y        <= w_y;
            r_flags    <= w_flags;
            r_sat      <= w_sat;
            r_cf       <= w_flags[FLG_C];
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign y         = r_y;
    assign flags     = r_flags;
    assign sat       = r_sat;
    assign cf        = r_cf;

endmodule
